// File: rtl/rnn_ctrl_pkg.sv
// Shared definitions for the rnn sequencer: rnn core register map, core
// status word bit positions and the sequencer FSM state encoding.
package rnn_ctrl_pkg;

  // rnn core register map (word addresses on the core slave port)
  localparam logic [31:0] ADDR_START = 32'd0;  // write: step start, read: status
  localparam logic [31:0] ADDR_INPUT = 32'd1;  // write: {word index, embedding word}
  localparam logic [31:0] ADDR_W     = 32'd2;
  localparam logic [31:0] ADDR_R     = 32'd3;
  localparam logic [31:0] ADDR_RB    = 32'd4;
  localparam logic [31:0] ADDR_D     = 32'd5;
  localparam logic [31:0] ADDR_DB    = 32'd6;
  localparam logic [31:0] ADDR_DENSE = 32'd7;  // write: dense start, read: result

  // core status word bits (read at ADDR_START)
  localparam int STAT_STEP_DONE    = 0;
  localparam int STAT_RESULT_VALID = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CHAR,
    S_FETCH,
    S_STEP,
    S_POLL,
    S_DENSE,
    S_DPOLL,
    S_RESULT
  } state_t;

endpackage

// File: rtl/rnn_seq_ctrl_if.sv
// Bus bundle between the sequencer and its two slaves: the embedding
// memory (read-only, one-cycle read latency) and the rnn core slave port
// (memory-mapped registers, read data one cycle after core_read).
//   master : sequencer side (drives strobes, addresses, write data)
//   slave  : embedding memory / rnn core side (returns read data)
interface rnn_seq_ctrl_if #(
  parameter int CHAR_W = 8
);
  logic              emb_rd;
  logic [CHAR_W+1:0] emb_addr;
  logic [15:0]       emb_rdata;
  logic              core_write;
  logic              core_read;
  logic [31:0]       core_addr;
  logic [31:0]       core_wdata;
  logic [31:0]       core_rdata;

  modport master (
    output emb_rd, emb_addr, core_write, core_read, core_addr, core_wdata,
    input  emb_rdata, core_rdata
  );

  modport slave (
    input  emb_rd, emb_addr, core_write, core_read, core_addr, core_wdata,
    output emb_rdata, core_rdata
  );
endinterface

// File: rtl/rnn_char_fifo.sv
// Character FIFO feeding the sequencer. First-word-fall-through: dout shows
// the head entry whenever empty=0. Pointers wrap modulo DEPTH (power of 2).
// A push on a full FIFO is taken when a pop happens in the same cycle.
// flush empties the FIFO and drops any push of that cycle.
// Ports:
//   clk, rst      clock, async active-high reset
//   flush         empty the FIFO
//   push, din     write request and data
//   pop           read request (advances head)
//   dout          head entry
//   full, empty   occupancy flags
module rnn_char_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rnn_seq_ctrl.sv
// rnn_seq_ctrl: runs a whole character sequence through the rnn core.
// Per character: pop from the char FIFO, fetch EMB_DIM embedding words,
// write them to core addr 1, start a step (addr 0 write) and poll the
// status word until step_done. After the last character it starts the
// dense layer (addr 7), polls until result_valid and reads the result.
// Optional build macro: RNN_SEQ_TIMEOUT_EN enables a per-wait poll timeout
// (TIMEOUT cycles) that aborts the sequence and raises error.
// Ports:
//   clk, rst                  clock, async active-high reset
//   char_in/valid/ready       character push into the FIFO
//   seq_start, seq_len        start pulse and sequence length (sampled)
//   busy, done                sequence in progress / one-cycle end pulse
//   result, result_valid      dense output and its valid flag
//   error                     timeout abort flag (0 without the macro)
//   bus                       embedding memory + core port (master side)
module rnn_seq_ctrl
  import rnn_ctrl_pkg::*;
#(
  parameter int EMB_DIM    = 4,
  parameter int CHAR_W     = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] char_in,
  input  logic              char_valid,
  output logic              char_ready,
  input  logic              seq_start,
  input  logic [7:0]        seq_len,
  output logic              busy,
  output logic              done,
  output logic [15:0]       result,
  output logic              result_valid,
  output logic              error,
  rnn_seq_ctrl_if.master    bus
);

  // state       | meaning
  // S_IDLE      | waiting for seq_start
  // S_WAIT_CHAR | waiting for a character in the FIFO; pops it on exit
  // S_FETCH     | embedding reads, each word written to core addr 1 a cycle later
  // S_STEP      | step start write (addr 0, data 0)
  // S_POLL      | read status until step_done, then next char or dense
  // S_DENSE     | dense start write (addr 7)
  // S_DPOLL     | read status until result_valid
  // S_RESULT    | read addr 7 and capture the result

  state_t            state_q;
  logic [CHAR_W-1:0] ch_q;
  logic [7:0]        rem_q;
  logic [2:0]        rd_idx_q;
  logic [1:0]        widx_q;
  logic              wsel_q;

  logic              emb_rd_q;
  logic [CHAR_W+1:0] emb_addr_q;
  logic              core_write_q;
  logic              core_read_q;
  logic [31:0]       core_addr_q;
  logic [31:0]       core_wdata_q;
  logic              busy_q;
  logic              done_q;
  logic [15:0]       result_q;
  logic              result_valid_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_flush;
  logic [CHAR_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              poll_hit;

  assign char_ready = !fifo_full;
  assign fifo_push  = char_valid && char_ready;
  assign fifo_pop   = (state_q == S_WAIT_CHAR) && !fifo_empty;

  rnn_char_fifo #(
    .WIDTH (CHAR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (char_in),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Status sample cycle: the read was issued last cycle (core_read_q low now).
  always_comb begin
    poll_hit = 1'b0;
    if (state_q == S_POLL)
      poll_hit = !core_read_q && bus.core_rdata[STAT_STEP_DONE];
    else if (state_q == S_DPOLL)
      poll_hit = !core_read_q && bus.core_rdata[STAT_RESULT_VALID];
  end

`ifdef RNN_SEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  logic [TMR_W-1:0] tmr_q;
  logic             error_q;
  logic             abort;

  assign abort      = ((state_q == S_POLL) || (state_q == S_DPOLL)) &&
                      (tmr_q == '0) && !poll_hit;
  assign fifo_flush = abort;
  assign error      = error_q;

  // Down-counter loaded on the way into POLL/DPOLL; terminal count aborts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else if ((state_q == S_STEP) || (state_q == S_DENSE)) begin
      tmr_q <= TMR_W'(TIMEOUT - 1);
    end else if (tmr_q != '0) begin
      tmr_q <= tmr_q - 1'b1;
    end
  end
`else
  assign fifo_flush = 1'b0;
  assign error      = 1'b0;
`endif

  // Embedding words go straight from the memory read port onto core_wdata
  // in their write cycle; core_wdata_q keeps the value afterwards.
  assign bus.core_wdata = wsel_q ? {14'd0, widx_q, bus.emb_rdata} : core_wdata_q;
  assign bus.emb_rd     = emb_rd_q;
  assign bus.emb_addr   = emb_addr_q;
  assign bus.core_write = core_write_q;
  assign bus.core_read  = core_read_q;
  assign bus.core_addr  = core_addr_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign result         = result_q;
  assign result_valid   = result_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      ch_q           <= '0;
      rem_q          <= '0;
      rd_idx_q       <= '0;
      widx_q         <= '0;
      wsel_q         <= 1'b0;
      emb_rd_q       <= 1'b0;
      emb_addr_q     <= '0;
      core_write_q   <= 1'b0;
      core_read_q    <= 1'b0;
      core_addr_q    <= '0;
      core_wdata_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
`ifdef RNN_SEQ_TIMEOUT_EN
      error_q        <= 1'b0;
`endif
    end else begin
      done_q       <= 1'b0;
      emb_rd_q     <= 1'b0;
      core_write_q <= 1'b0;
      core_read_q  <= 1'b0;
      wsel_q       <= 1'b0;
      if (wsel_q) core_wdata_q <= {14'd0, widx_q, bus.emb_rdata};

      case (state_q)
        S_IDLE: begin
          if (seq_start) begin
            result_valid_q <= 1'b0;
`ifdef RNN_SEQ_TIMEOUT_EN
            error_q        <= 1'b0;
`endif
            if (seq_len == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              busy_q  <= 1'b1;
              rem_q   <= seq_len;
              state_q <= S_WAIT_CHAR;
            end
          end
        end

        S_WAIT_CHAR: begin
          if (!fifo_empty) begin
            ch_q       <= fifo_dout;
            emb_rd_q   <= 1'b1;
            emb_addr_q <= {fifo_dout, 2'd0};
            rd_idx_q   <= 3'd1;
            state_q    <= S_FETCH;
          end
        end

        S_FETCH: begin
          // word read this cycle is returned and written next cycle
          if (emb_rd_q) begin
            core_write_q <= 1'b1;
            wsel_q       <= 1'b1;
            widx_q       <= emb_addr_q[1:0];
            core_addr_q  <= ADDR_INPUT;
          end
          if (emb_rd_q && (rd_idx_q < 3'(EMB_DIM))) begin
            emb_rd_q   <= 1'b1;
            emb_addr_q <= {ch_q, rd_idx_q[1:0]};
            rd_idx_q   <= rd_idx_q + 3'd1;
          end
          if (wsel_q && (widx_q == 2'(EMB_DIM - 1))) begin
            core_write_q <= 1'b1;
            core_addr_q  <= ADDR_START;
            core_wdata_q <= '0;
            state_q      <= S_STEP;
          end
        end

        S_STEP: begin
          core_read_q <= 1'b1;
          core_addr_q <= ADDR_START;
          state_q     <= S_POLL;
        end

        S_POLL: begin
          if (poll_hit) begin
            rem_q <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              core_write_q <= 1'b1;
              core_addr_q  <= ADDR_DENSE;
              core_wdata_q <= '0;
              state_q      <= S_DENSE;
            end else begin
              state_q <= S_WAIT_CHAR;
            end
          end else if (!core_read_q) begin
            core_read_q <= 1'b1;
          end
        end

        S_DENSE: begin
          core_read_q <= 1'b1;
          core_addr_q <= ADDR_START;
          state_q     <= S_DPOLL;
        end

        S_DPOLL: begin
          if (poll_hit) begin
            core_read_q <= 1'b1;
            core_addr_q <= ADDR_DENSE;
            state_q     <= S_RESULT;
          end else if (!core_read_q) begin
            core_read_q <= 1'b1;
          end
        end

        S_RESULT: begin
          if (!core_read_q) begin
            result_q       <= bus.core_rdata[15:0];
            result_valid_q <= 1'b1;
            done_q         <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase

`ifdef RNN_SEQ_TIMEOUT_EN
      if (abort) begin
        error_q        <= 1'b1;
        done_q         <= 1'b1;
        busy_q         <= 1'b0;
        result_valid_q <= 1'b0;
        core_read_q    <= 1'b0;
        state_q        <= S_IDLE;
      end
`endif
    end
  end

endmodule
